// File: rtl/hazard_unit_if.sv
// D-stage hazard query bundle: operand/destination codes in, stall and forward selects out.
interface hazard_unit_if;
  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic [2:0] tuse_s_D;
  logic [2:0] tuse_t_D;
  logic [4:0] a3_D;
  logic [2:0] tnew_D;
  logic       stall;
  logic [1:0] fwd_rs_D;
  logic [1:0] fwd_rt_D;
  logic [1:0] fwd_rs_E;
  logic [1:0] fwd_rt_E;

  modport master (
    output rs_D, rt_D, tuse_s_D, tuse_t_D, a3_D, tnew_D,
    input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E
  );

  modport slave (
    input  rs_D, rt_D, tuse_s_D, tuse_t_D, a3_D, tnew_D,
    output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E
  );
endinterface

// File: rtl/hazard_unit.sv
// Stall/forward controller for the five-stage core: a three-entry scoreboard of
// in-flight destinations (E/M/W) with remaining TNew, compared against D-stage TUse.
module hazard_unit (
  input logic          clk,
  input logic          reset,
  hazard_unit_if.slave hif
);
  logic [4:0] r_e_a3, r_e_rs, r_e_rt, r_m_a3, r_w_a3;
  logic [2:0] r_e_tnew, r_m_tnew, r_w_tnew;
  logic       w_stall_s, w_stall_t, w_stall;
  logic [1:0] w_fwd_rs_D, w_fwd_rt_D, w_fwd_rs_E, w_fwd_rt_E;

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  function automatic logic stall_op(
    input logic [4:0] r,    input logic [2:0] tuse,
    input logic [4:0] e_a3, input logic [2:0] e_tnew,
    input logic [4:0] m_a3, input logic [2:0] m_tnew
  );
    if (tuse == 3'd4 || r == 5'd0) return 1'b0;
    return ((e_a3 == r) && (e_tnew > tuse)) || ((m_a3 == r) && (m_tnew > tuse));
  endfunction

  // Nearest matching stage decides; a match still producing blocks older copies.
  function automatic logic [1:0] fwd_d(
    input logic [4:0] r,
    input logic [4:0] e_a3, input logic [2:0] e_tnew,
    input logic [4:0] m_a3, input logic [2:0] m_tnew,
    input logic [4:0] w_a3, input logic [2:0] w_tnew
  );
    if (r == 5'd0)  return 2'd0;
    if (e_a3 == r)  return (e_tnew == 3'd0) ? 2'd1 : 2'd0;
    if (m_a3 == r)  return (m_tnew == 3'd0) ? 2'd2 : 2'd0;
    if (w_a3 == r)  return (w_tnew == 3'd0) ? 2'd3 : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [1:0] fwd_e(
    input logic [4:0] r,
    input logic [4:0] m_a3, input logic [2:0] m_tnew,
    input logic [4:0] w_a3
  );
    if (r == 5'd0)                      return 2'd0;
    if (m_a3 == r && m_tnew == 3'd0)    return 2'd1;
    if (w_a3 == r)                      return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    w_stall_s  = stall_op(hif.rs_D, hif.tuse_s_D, r_e_a3, r_e_tnew, r_m_a3, r_m_tnew);
    w_stall_t  = stall_op(hif.rt_D, hif.tuse_t_D, r_e_a3, r_e_tnew, r_m_a3, r_m_tnew);
    w_stall    = w_stall_s | w_stall_t;
    w_fwd_rs_D = fwd_d(hif.rs_D, r_e_a3, r_e_tnew, r_m_a3, r_m_tnew, r_w_a3, r_w_tnew);
    w_fwd_rt_D = fwd_d(hif.rt_D, r_e_a3, r_e_tnew, r_m_a3, r_m_tnew, r_w_a3, r_w_tnew);
    w_fwd_rs_E = fwd_e(r_e_rs, r_m_a3, r_m_tnew, r_w_a3);
    w_fwd_rt_E = fwd_e(r_e_rt, r_m_a3, r_m_tnew, r_w_a3);
  end

  assign hif.stall    = w_stall;
  assign hif.fwd_rs_D = w_fwd_rs_D;
  assign hif.fwd_rt_D = w_fwd_rt_D;
  assign hif.fwd_rs_E = w_fwd_rs_E;
  assign hif.fwd_rt_E = w_fwd_rt_E;

  // M and W always advance; only the E entry sees the stall bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_a3   <= 5'd0;
      r_e_tnew <= 3'd0;
      r_e_rs   <= 5'd0;
      r_e_rt   <= 5'd0;
      r_m_a3   <= 5'd0;
      r_m_tnew <= 3'd0;
      r_w_a3   <= 5'd0;
      r_w_tnew <= 3'd0;
    end else begin
      r_w_a3   <= r_m_a3;
      r_w_tnew <= sat_dec(r_m_tnew);
      r_m_a3   <= r_e_a3;
      r_m_tnew <= sat_dec(r_e_tnew);
      if (w_stall) begin
        r_e_a3   <= 5'd0;
        r_e_tnew <= 3'd0;
        r_e_rs   <= 5'd0;
        r_e_rt   <= 5'd0;
      end else begin
        r_e_a3   <= hif.a3_D;
        r_e_tnew <= sat_dec(hif.tnew_D);
        r_e_rs   <= hif.rs_D;
        r_e_rt   <= hif.rt_D;
      end
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed cycle-by-cycle vectors for hazard_unit, plus a reset-during-stall sequence.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic reset;
  hazard_unit_if hif();

  hazard_unit dut (.clk(clk), .reset(reset), .hif(hif));

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic [2:0] ts, tt;
    logic [4:0] a3;
    logic [2:0] tn;
    logic       chk;
    logic       st;
    logic [1:0] fsd, ftd, fse, fte;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit run_done = 1'b0;

  function automatic vec_t mk(input int rst, input int rs, input int rt, input int ts,
                              input int tt, input int a3, input int tn, input int chk,
                              input int st, input int fsd, input int ftd, input int fse,
                              input int fte);
    vec_t v;
    v.rst = 1'(rst); v.rs = 5'(rs); v.rt = 5'(rt); v.ts = 3'(ts); v.tt = 3'(tt);
    v.a3 = 5'(a3); v.tn = 3'(tn); v.chk = 1'(chk); v.st = 1'(st);
    v.fsd = 2'(fsd); v.ftd = 2'(ftd); v.fse = 2'(fse); v.fte = 2'(fte);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset        = v.rst;
    hif.rs_D     = v.rs;
    hif.rt_D     = v.rt;
    hif.tuse_s_D = v.ts;
    hif.tuse_t_D = v.tt;
    hif.a3_D     = v.a3;
    hif.tnew_D   = v.tn;
  endtask

  task automatic check_outs(input int idx, input vec_t v);
    check("stall",    idx, int'(hif.stall),    int'(v.st));
    check("fwd_rs_D", idx, int'(hif.fwd_rs_D), int'(v.fsd));
    check("fwd_rt_D", idx, int'(hif.fwd_rt_D), int'(v.ftd));
    check("fwd_rs_E", idx, int'(hif.fwd_rs_E), int'(v.fse));
    check("fwd_rt_E", idx, int'(hif.fwd_rt_E), int'(v.fte));
  endtask

  // W entry never holds a pending result.
  always @(negedge clk) begin
    if (!run_done) check("w_tnew_zero", -1, int'(dut.r_w_tnew), 0);
  end

  initial begin
    vec_t v;
    // rst, rs,rt,ts,tt,a3,tn, chk, st,fsd,ftd,fse,fte
    vecs.push_back(mk(1, 0,0,4,4,0,0, 0, 0,0,0,0,0));
    vecs.push_back(mk(0, 0,0,4,4,0,0, 1, 0,0,0,0,0));
    // lw $8 then addu rs=8 tuse 1
    vecs.push_back(mk(0, 0,0,1,4,8,3, 1, 0,0,0,0,0));
    vecs.push_back(mk(0, 8,0,1,1,10,2, 1, 1,0,0,0,0));
    vecs.push_back(mk(0, 8,0,1,1,10,2, 1, 0,0,0,0,0));
    vecs.push_back(mk(0, 0,0,4,4,0,0, 1, 0,0,0,2,0));
    // addu $9 then beq $9,$9
    vecs.push_back(mk(0, 0,0,1,1,9,2, 1, 0,0,0,0,0));
    vecs.push_back(mk(0, 9,9,0,0,0,0, 1, 1,0,0,0,0));
    vecs.push_back(mk(0, 9,9,0,0,0,0, 1, 0,2,2,0,0));
    // lw $8 then beq rs=8 (beq in E now gets W forward on both operands)
    vecs.push_back(mk(0, 0,0,1,4,8,3, 1, 0,0,0,2,2));
    vecs.push_back(mk(0, 8,0,0,0,0,0, 1, 1,0,0,0,0));
    vecs.push_back(mk(0, 8,0,0,0,0,0, 1, 1,0,0,0,0));
    vecs.push_back(mk(0, 8,0,0,0,0,0, 1, 0,3,0,0,0));
    // two writers of $5, reader two cycles later
    vecs.push_back(mk(0, 0,0,1,1,5,2, 1, 0,0,0,0,0));
    vecs.push_back(mk(0, 0,0,1,1,5,2, 1, 0,0,0,0,0));
    vecs.push_back(mk(0, 0,0,4,4,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0, 5,0,1,4,0,0, 1, 0,2,0,0,0));
    // producer targeting $0, consumers of $0
    vecs.push_back(mk(0, 0,0,4,4,0,3, 1, 0,0,0,2,0));
    vecs.push_back(mk(0, 0,0,0,0,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0, 0,0,0,0,0,0, 1, 0,0,0,0,0));
    // lw $7, unused operands, then rt-only stall
    vecs.push_back(mk(0, 0,0,1,4,7,3, 1, 0,0,0,0,0));
    vecs.push_back(mk(0, 7,7,4,4,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0, 0,7,4,0,0,0, 1, 1,0,0,0,0));
    vecs.push_back(mk(0, 0,7,4,0,0,0, 1, 0,0,3,0,0));
    // addu $3 then consumer: E-stage forward from M
    vecs.push_back(mk(0, 0,0,1,1,3,2, 1, 0,0,0,0,0));
    vecs.push_back(mk(0, 3,3,1,1,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0, 0,0,4,4,0,0, 1, 0,0,0,1,1));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      if (vecs[i].chk) check_outs(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Reset arriving in the first cycle of the lw->addu stall.
    drive(mk(1, 0,0,4,4,0,0, 0, 0,0,0,0,0));
    @(posedge clk); #1;
    drive(mk(0, 0,0,1,4,8,3, 0, 0,0,0,0,0));
    @(posedge clk); #1;
    v = mk(0, 8,8,1,1,10,2, 0, 0,0,0,0,0);
    drive(v);
    @(negedge clk);
    check("rst_stall_pre", 100, int'(hif.stall), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_outs(101, v);
    check("rst_records", 101, int'(dut.r_e_a3 | dut.r_m_a3 | dut.r_w_a3), 0);
    check("rst_tnews",   101, int'(dut.r_e_tnew | dut.r_m_tnew), 0);
    @(posedge clk); #1;

    run_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
